result_stream_tx: RTL and testbench
===================================

// Module: result_stream_tx
// PURPOSE
//   AXI4-Stream transmitter for NPU results; the counterpart of axi_stream_input.
//   On start it reads out_size words from the result SRAM (ELEM0 bank, via the
//   sram_controller output port) and emits one beat per word on the m_axis master port.
//   Handles backpressure through a 2-entry prefetch FIFO and sustains 1 beat/cycle.
// PARAMETERS
//   ADDR_WIDTH          13  SRAM address / element-count width
//   DATA_WIDTH          8   base data width; each beat carries 2*DATA_WIDTH bits
//   NUM_CHANNELS_WIDTH  7   tuser width (channel count)
// PORTS
//   clk            in   1                     single clock
//   rst            in   1                     synchronous reset, active-high
//   start          in   1                     pulse: begin a transfer; ignored while busy
//   out_size       in   ADDR_WIDTH            number of beats; sampled when start is accepted
//   num_channels   in   NUM_CHANNELS_WIDTH    sampled when start is accepted; driven on tuser
//   busy           out  1                     high from accepted start until done
//   done           out  1                     1-cycle pulse after the final beat handshake
//   sram_out_en    out  1                     SRAM read strobe
//   sram_out_addr  out  ADDR_WIDTH            SRAM read address, 0..out_size-1
//   sram_out_data  in   2*DATA_WIDTH          read data, valid 1 cycle after sram_out_en
//   m_axis_tdata   out  2*DATA_WIDTH          beat data (signed)
//   m_axis_tstrb   out  2*DATA_WIDTH/8        all ones while tvalid, else 0
//   m_axis_tvalid  out  1
//   m_axis_tready  in   1
//   m_axis_tlast   out  1                     high on beat index out_size-1 only
//   m_axis_tuser   out  NUM_CHANNELS_WIDTH    latched num_channels
// BEHAVIOUR
//   Reset: busy, done, sram_out_en, m_axis_tvalid, m_axis_tlast and m_axis_tstrb = 0;
//     sram_out_addr, m_axis_tdata and m_axis_tuser = 0; FIFO emptied; state = IDLE.
//   FSM:
//     IDLE   -> STREAM on start when out_size != 0; latch size and channels; rd_addr = 0.
//     IDLE   -> FINISH on start when out_size == 0; no SRAM read and no beat.
//     STREAM -> DRAIN once the last read (rd_addr == size-1) is issued.
//     DRAIN  -> FINISH on the handshake (tvalid & tready) of the tlast beat.
//     FINISH -> IDLE after 1 cycle; done = 1 in FINISH. busy = 1 in STREAM/DRAIN/FINISH.
//   Read issue, STREAM only:
//     Issue when fifo_count + inflight - pop_this_cycle < 2.
//     Issue means sram_out_en = 1 with sram_out_addr = rd_addr; rd_addr then increments.
//     inflight is 1 in the cycle after an issue. Data is pushed into the FIFO on the next edge.
//     The FIFO can never overflow. A push and a pop in the same cycle are both legal.
//   Output:
//     The FIFO head drives tdata/tvalid, registered. tvalid = FIFO not empty.
//     While tvalid & !tready: tdata, tlast and tuser stay stable and tvalid stays high.
//     beat_cnt increments on each handshake. tlast = (beat_cnt == size-1) & tvalid.
//   Latency:
//     start in cycle 0 -> sram_out_en in cycle 1 -> first tvalid in cycle 3.
//     With tready held high, beats follow every cycle; done is 1 cycle after the last handshake.
//   Boundaries:
//     size 1: one beat with tlast.
//     size = 2^ADDR_WIDTH-1: the counters must not wrap before tlast.
//     start during busy: ignored; no re-latch.
//     Changes to num_channels or out_size mid-transfer: no effect.
//     rst mid-transfer: all outputs at reset values after that edge; any in-flight read
//       is discarded; the next start begins again at address 0.
// STRUCTURE
//   params.vh: tx FSM state localparams (TX_IDLE/TX_STREAM/TX_DRAIN/TX_FINISH) and
//     ELEM0_SRAM_IDX (the sram_controller instance ties sram_out_idx to it).
//   Sub-module stream_skid_fifo: 2-entry synchronous FIFO, width 2*DATA_WIDTH+1 (data+last).
//     Ports: push/pop/full/empty/count, with simultaneous push+pop when not empty.
//   The top level holds the FSM, the read-credit logic and the counters.
// TESTING
//   1 out_size=4, mem[i]=3*i, tready=1 -> tdata 0,3,6,9 on consecutive cycles from cycle 3;
//     tlast on 9; done 1 cycle later.
//   2 out_size=6, tready toggling 1,0,1,0 -> beats 0..5 exactly once, in order; tdata stable
//     while stalled; fifo_count+inflight <= 2 at all times.
//   3 out_size=1 -> exactly one beat, with tvalid & tlast both high; busy low 2 cycles later.
//   4 out_size=0 -> no sram_out_en, no tvalid; done pulses in cycle 1.
//   5 out_size=8, assert rst after beat 2 -> tvalid, busy and sram_out_en 0 after the edge;
//     a new start streams from address 0 with correct data.
//   6 num_channels=3 at start, changed to 9 mid-stream, plus a second start while busy ->
//     tuser stays 3 throughout, one tlast, one done.

Source files
------------

// File: rtl/result_stream_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : result_stream_tx_pkg                                         |
// | Purpose   : Shared types and constants for the NPU result stream         |
// |             transmitter (tx FSM states, SRAM bank index, FIFO depth).    |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package result_stream_tx_pkg;

   // Transmit FSM states
   typedef enum logic [1:0] {
      TX_IDLE   = 2'd0,
      TX_STREAM = 2'd1,
      TX_DRAIN  = 2'd2,
      TX_FINISH = 2'd3
   } tx_state_e;

   // Result data lives in the ELEM0 bank; the sram_controller instance ties
   // its sram_out_idx to this value.
   localparam int ELEM0_SRAM_IDX = 0;

   // Prefetch depth: reads outstanding (queued + in flight) never exceed this
   localparam int FIFO_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/result_stream_tx_skid_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : result_stream_tx_skid_fifo                                   |
// | Purpose   : 2-entry synchronous stream skid FIFO. The head entry is held |
// |             in a register and presented directly on data_o, so the       |
// |             stream output is registered. Push and pop in the same cycle  |
// |             are allowed whenever the FIFO is not empty.                  |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module result_stream_tx_skid_fifo #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A pop frees the head slot at the same edge, so a push into a full FIFO
   // is accepted only together with a pop.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Storage, pointers and occupancy; storage is cleared so the output data
   // reads zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/result_stream_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : result_stream_tx                                             |
// | Purpose   : AXI4-Stream transmitter for NPU results. On start, reads     |
// |             out_size words from the result SRAM and emits one beat per   |
// |             word, with a 2-entry prefetch FIFO absorbing backpressure    |
// |             while sustaining one beat per cycle.                         |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module result_stream_tx
   import result_stream_tx_pkg::*;
#(
   parameter int ADDR_WIDTH         = 13,
   parameter int DATA_WIDTH         = 8,
   parameter int NUM_CHANNELS_WIDTH = 7
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [ADDR_WIDTH-1:0]             out_size,
   input  logic [NUM_CHANNELS_WIDTH-1:0]     num_channels,
   output logic                              busy,
   output logic                              done,
   output logic                              sram_out_en,
   output logic [ADDR_WIDTH-1:0]             sram_out_addr,
   input  logic [2*DATA_WIDTH-1:0]           sram_out_data,
   output logic signed [2*DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [2*DATA_WIDTH/8-1:0]         m_axis_tstrb,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic [NUM_CHANNELS_WIDTH-1:0]     m_axis_tuser
);

   localparam int BEAT_W = 2 * DATA_WIDTH;
   localparam int STRB_W = BEAT_W / 8;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   tx_state_e                     state_q;
   logic [ADDR_WIDTH-1:0]         size_q;
   logic [ADDR_WIDTH-1:0]         rd_addr_q;
   logic [ADDR_WIDTH-1:0]         beat_cnt_q;
   logic [NUM_CHANNELS_WIDTH-1:0] chan_q;
   logic                          inflight_q;
   logic                          inflight_last_q;

   logic                          issue;
   logic                          pop;
   logic                          push;
   logic                          last_rd;
   logic                          last_beat;
   logic [2:0]                    credit_used;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [1:0]                    fifo_count;
   logic [BEAT_W:0]               fifo_head;

   // ---------------- read-credit logic ----------------
   // A beat leaves the FIFO whenever the head is valid and the sink is ready.
   assign pop         = ~fifo_empty & m_axis_tready;
   // Read data returns one cycle after the strobe; that is the in-flight slot.
   assign push        = inflight_q & (~fifo_full | pop);
   assign last_rd     = (rd_addr_q == size_q - ADDR_ONE);
   assign last_beat   = (beat_cnt_q == size_q - ADDR_ONE);
   // Counting this cycle's pop as already freed is what allows 1 beat/cycle.
   assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue       = (state_q == TX_STREAM) && (credit_used < 3'(FIFO_DEPTH));

   assign sram_out_en   = issue;
   assign sram_out_addr = rd_addr_q;

   // ---------------- status and stream outputs ----------------
   assign busy          = (state_q != TX_IDLE);
   assign done          = (state_q == TX_FINISH);
   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tdata  = fifo_head[BEAT_W-1:0];
   assign m_axis_tlast  = fifo_head[BEAT_W] & ~fifo_empty;
   assign m_axis_tstrb  = {STRB_W{~fifo_empty}};
   assign m_axis_tuser  = chan_q;

   // FSM, latched transfer parameters, read address and beat counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= TX_IDLE;
         size_q          <= '0;
         chan_q          <= '0;
         rd_addr_q       <= '0;
         beat_cnt_q      <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         inflight_q      <= issue;
         inflight_last_q <= issue & last_rd;
         if (issue) begin
            rd_addr_q <= rd_addr_q + ADDR_ONE;
         end
         if (pop) begin
            beat_cnt_q <= beat_cnt_q + ADDR_ONE;
         end
         case (state_q)
            TX_IDLE: begin
               if (start) begin
                  size_q     <= out_size;
                  chan_q     <= num_channels;
                  rd_addr_q  <= '0;
                  beat_cnt_q <= '0;
                  state_q    <= (out_size == '0) ? TX_FINISH : TX_STREAM;
               end
            end
            TX_STREAM: begin
               if (issue && last_rd) begin
                  state_q <= TX_DRAIN;
               end
            end
            TX_DRAIN: begin
               if (pop && last_beat) begin
                  state_q <= TX_FINISH;
               end
            end
            TX_FINISH: begin
               state_q <= TX_IDLE;
            end
            default: begin
               state_q <= TX_IDLE;
            end
         endcase
      end
   end

   // Prefetch FIFO carrying {last, data}
   result_stream_tx_skid_fifo #(
      .WIDTH (BEAT_W + 1)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  ({inflight_last_q, sram_out_data}),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_result_stream_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_result_stream_tx                                          |
// | Purpose   : Self-checking bench for result_stream_tx with an SRAM model  |
// |             and a beat-queue reference model.                            |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_result_stream_tx;

   localparam int AW = 13;
   localparam int DW = 8;
   localparam int CW = 7;
   localparam int BW = 2 * DW;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [AW-1:0]        out_size;
   logic [CW-1:0]        num_channels;
   logic                 busy;
   logic                 done;
   logic                 sram_out_en;
   logic [AW-1:0]        sram_out_addr;
   logic [BW-1:0]        sram_out_data;
   logic signed [BW-1:0] m_axis_tdata;
   logic [BW/8-1:0]      m_axis_tstrb;
   logic                 m_axis_tvalid;
   logic                 m_axis_tready;
   logic                 m_axis_tlast;
   logic [CW-1:0]        m_axis_tuser;

   typedef struct packed {
      logic          last;
      logic [BW-1:0] data;
   } beat_t;

   beat_t         exp_q[$];
   beat_t         e_cur;
   logic [BW-1:0] mem [0:(1<<AW)-1];

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc = 0;
   int c0  = 0;
   int rel = 0;
   bit mon_en  = 0;
   int rd_mode = 0;
   int exp_size, exp_chan;
   int reads, beats, dones, next_addr;
   int first_en, first_valid, done_rel, last_hs, busy_fall;
   bit stalled;

   result_stream_tx #(
      .ADDR_WIDTH         (AW),
      .DATA_WIDTH         (DW),
      .NUM_CHANNELS_WIDTH (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .out_size      (out_size),
      .num_channels  (num_channels),
      .busy          (busy),
      .done          (done),
      .sram_out_en   (sram_out_en),
      .sram_out_addr (sram_out_addr),
      .sram_out_data (sram_out_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read SRAM: data is valid the cycle after the strobe
   always @(posedge clk) begin
      if (sram_out_en) sram_out_data <= mem[sram_out_addr];
   end

   // Sink readiness: 0 = always ready, 1 = alternating, other = random
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rd_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Stream monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (mon_en) begin
         rel = cyc - c0;
         // reads issued minus beats taken = FIFO occupancy + in-flight read
         check_eq("outstanding_le2", (reads - beats) <= 2, 1);
         if (sram_out_en) begin
            check_eq("rd_addr", sram_out_addr, next_addr);
            check_eq("rd_within_size", reads < exp_size, 1);
            if (first_en < 0) first_en = rel;
            next_addr++;
            reads++;
         end
         if (m_axis_tvalid) begin
            check_eq("tstrb", m_axis_tstrb, 2'b11);
            check_eq("tuser", m_axis_tuser, exp_chan);
            if (first_valid < 0) first_valid = rel;
            if (exp_q.size() == 0) begin
               check_eq("beat_overrun", beats + 1, exp_size);
            end else begin
               e_cur = exp_q[0];
               check_eq("tdata", {16'h0, m_axis_tdata}, {16'h0, e_cur.data});
               check_eq("tlast", m_axis_tlast, e_cur.last);
               if (m_axis_tready) begin
                  void'(exp_q.pop_front());
                  if (e_cur.last) last_hs = rel;
               end
            end
            if (m_axis_tready) beats++;
            stalled = ~m_axis_tready;
         end else begin
            if (stalled) check_eq("valid_held", m_axis_tvalid, 1);
            check_eq("idle_tlast", m_axis_tlast, 0);
            check_eq("idle_tstrb", m_axis_tstrb, 0);
            stalled = 0;
         end
         if (done) begin
            dones++;
            done_rel = rel;
         end
         if (!busy && busy_fall < 0 && rel > 0) busy_fall = rel;
      end
   end

   task automatic prep(input int size, input int chan, input int mode, input bit fill3);
      for (int i = 0; i < size; i++) mem[i] = fill3 ? BW'(3 * i) : BW'($urandom);
      exp_q.delete();
      for (int i = 0; i < size; i++) exp_q.push_back(beat_t'{last: (i == size - 1), data: mem[i]});
      exp_size = size;  exp_chan = chan;
      reads = 0;  beats = 0;  dones = 0;  next_addr = 0;
      first_en = -1;  first_valid = -1;  done_rel = -1;  last_hs = -1;  busy_fall = -1;
      stalled = 0;
      rd_mode = mode;
   endtask

   task automatic kick(input int size, input int chan, input int chan_after);
      @(posedge clk); #1;
      start = 1'b1;  out_size = AW'(size);  num_channels = CW'(chan);
      c0 = cyc;  mon_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;  out_size = AW'($urandom);  num_channels = CW'(chan_after);
   endtask

   task automatic run_xfer(input int size, input int chan, input int mode, input bit fill3,
                           input bit extra_start, input int chan_after);
      int budget;
      prep(size, chan, mode, fill3);
      kick(size, chan, chan_after);
      budget = 8 * size + 50;
      while (dones == 0 && budget > 0) begin
         start = (extra_start && (cyc - c0) == 3);
         if (start) out_size = AW'($urandom_range(1, 50));
         @(posedge clk); #1;
         budget--;
      end
      start = 1'b0;
      if (dones == 0) check_eq("done_timeout", dones, 1);
      repeat (4) @(posedge clk);
      #1;
      check_eq("beats", beats, size);
      check_eq("reads", reads, size);
      check_eq("done_count", dones, 1);
      check_eq("exp_left", exp_q.size(), 0);
      check_eq("busy_fall", busy_fall, done_rel + 1);
      if (size == 0) begin
         check_eq("first_en_none", first_en, -1);
         check_eq("first_valid_none", first_valid, -1);
         check_eq("done_rel_zero", done_rel, 1);
      end else begin
         check_eq("first_en", first_en, 1);
         check_eq("first_valid", first_valid, 3);
         check_eq("done_after_last", done_rel, last_hs + 1);
         if (mode == 0) check_eq("full_rate_done", done_rel, size + 3);
      end
      mon_en = 1'b0;
   endtask

   task automatic check_reset_outs();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_en", sram_out_en, 0);
      check_eq("rst_addr", sram_out_addr, 0);
      check_eq("rst_tvalid", m_axis_tvalid, 0);
      check_eq("rst_tlast", m_axis_tlast, 0);
      check_eq("rst_tstrb", m_axis_tstrb, 0);
      check_eq("rst_tdata", {16'h0, m_axis_tdata}, 0);
      check_eq("rst_tuser", m_axis_tuser, 0);
   endtask

   task automatic run_reset_mid();
      int budget;
      prep(8, 21, 0, 1'b0);
      kick(8, 21, 21);
      budget = 60;
      while (beats < 3 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      if (beats < 3) check_eq("reset_wait_timeout", beats, 3);
      mon_en = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outs();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;  start = 1'b0;  out_size = '0;  num_channels = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outs();
      @(posedge clk); #1;
      rst = 1'b0;

      run_xfer(4, 5, 0, 1'b1, 1'b0, 17);     // ramp data, full rate
      run_xfer(6, 44, 1, 1'b0, 1'b0, 2);     // alternating ready
      run_xfer(1, 7, 0, 1'b0, 1'b0, 7);      // single beat
      run_xfer(0, 9, 0, 1'b0, 1'b0, 9);      // empty transfer
      run_reset_mid();
      run_xfer(8, 12, 0, 1'b0, 1'b0, 40);    // restart from address 0
      run_xfer(10, 3, 2, 1'b0, 1'b1, 9);     // channel change + start while busy
      for (int t = 0; t < 6; t++) begin
         run_xfer($urandom_range(1, 24), $urandom_range(0, 127), 2, 1'b0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 127));
      end
      run_xfer((1 << AW) - 1, 100, 0, 1'b0, 1'b0, 1);  // largest size, no wrap

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
